// File: rtl/al_accel_bpbuf_feeder.sv
// Feeds upstream 32-bit words into a bypass buffer through a small FIFO.
// Each word is held on the load strobe for LD_CYCLES, then LD_CYCLES is followed by a GAP_CYCLES quiet phase.
module al_accel_bpbuf_feeder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LD_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic        start,
  input  logic [7:0]  word_cnt,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] bpbuf_di,
  output logic        bpbuf_ld_wrn,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ld_count
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned PH_MAX   = (LD_CYCLES > GAP_CYCLES) ? LD_CYCLES : GAP_CYCLES;
  localparam int unsigned PW       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PW-1:0] LD_LAST  = PW'(LD_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_GAP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [7:0]      tgt_q, tgt_d;
  logic [7:0]      ld_count_q, ld_count_d;
  logic [31:0]     di_q, di_d;
  logic            wrn_q, wrn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [31:0]     fifo_mem_q [FIFO_DEPTH];

  logic push_c, pop_c, clr_c, fifo_full_c, fifo_empty_c;

  assign fifo_full_c  = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty_c = (fifo_cnt_q == '0);
  assign s_ready      = enb & busy_q & ~fifo_full_c;
  assign push_c       = s_valid & s_ready;

  assign bpbuf_di     = di_q;
  assign bpbuf_ld_wrn = wrn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ld_count     = ld_count_q;

  // FIFO bookkeeping; power-of-two depth lets the pointers wrap naturally
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (clr_c) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem_q[wr_ptr_q] <= s_data;
  end

  // Job sequencer; a ready word at the end of GAP passes through WAIT in zero cycles
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tgt_d      = tgt_q;
    ld_count_d = ld_count_q;
    di_d       = di_q;
    wrn_d      = wrn_q;
    done_d     = 1'b0;
    pop_c      = 1'b0;
    clr_c      = 1'b0;
    if (enb) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            tgt_d      = word_cnt;
            ld_count_d = '0;
            state_d    = (word_cnt == 8'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: pop_c = ~fifo_empty_c;
        S_LOAD: begin
          if (phase_q == LD_LAST) begin
            phase_d = '0;
            wrn_d   = 1'b0;
            state_d = S_GAP;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_GAP: begin
          if (phase_q == GAP_LAST) begin
            phase_d = '0;
            if (ld_count_q == tgt_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
              pop_c   = ~fifo_empty_c;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          clr_c   = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (pop_c) begin
        di_d       = fifo_mem_q[rd_ptr_q];
        ld_count_d = ld_count_q + 8'd1;
        wrn_d      = 1'b1;
        phase_d    = '0;
        state_d    = S_LOAD;
      end
    end
    busy_d = (state_d == S_WAIT) || (state_d == S_LOAD) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      tgt_q      <= '0;
      ld_count_q <= '0;
      di_q       <= '0;
      wrn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tgt_q      <= tgt_d;
      ld_count_q <= ld_count_d;
      di_q       <= di_d;
      wrn_q      <= wrn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_al_accel_bpbuf_feeder.sv
// Directed bench for al_accel_bpbuf_feeder: accepted words are queued as expected
// loads and checked against bpbuf_di on every rising load strobe.
module tb_al_accel_bpbuf_feeder;

  localparam int unsigned LD = 2;

  logic        clk, reset, enb, start, s_valid, s_ready, bpbuf_ld_wrn, busy, done;
  logic [7:0]  word_cnt, ld_count;
  logic [31:0] s_data, bpbuf_di;

  int          n_cmp, n_err;
  logic [31:0] exp_q [$];
  logic [31:0] cur_di;
  int          rises, hi_run, lo_run, last_lo, dones, n_push;
  logic        last_acc, saw_full;

  al_accel_bpbuf_feeder #(.FIFO_DEPTH(4), .LD_CYCLES(2), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enb(enb), .start(start), .word_cnt(word_cnt),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .bpbuf_di(bpbuf_di),
    .bpbuf_ld_wrn(bpbuf_ld_wrn), .busy(busy), .done(done), .ld_count(ld_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: capture pre-edge handshake, then observe outputs 1ns after the edge
  task automatic tick();
    logic        acc, wb, eb;
    logic [31:0] sd, exp_w;
    acc = s_valid && s_ready;
    wb  = bpbuf_ld_wrn;
    eb  = enb;
    sd  = s_data;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (acc) begin
      exp_q.push_back(sd);
      n_push++;
    end
    if (eb) begin
      if (wb) hi_run++;
      else    lo_run++;
    end
    if (bpbuf_ld_wrn && !wb) begin
      rises++;
      last_lo = lo_run;
      lo_run  = 0;
      hi_run  = 0;
      cur_di  = bpbuf_di;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_underflow observed=%h expected=queued word", bpbuf_di);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk("load_word", bpbuf_di, exp_w);
      end
    end else if (bpbuf_ld_wrn && wb) begin
      chk("di_stable", bpbuf_di, cur_di);
    end
    if (!bpbuf_ld_wrn && wb) chk("ld_len", 32'(hi_run), 32'(LD));
    if (done === 1'b1) dones++;
  endtask

  task automatic push_word(input logic [31:0] w);
    int i;
    i       = 0;
    s_data  = w;
    s_valid = 1'b1;
    do begin
      tick();
      i++;
    end while (!last_acc && i < 50);
    s_valid = 1'b0;
    chk("push_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic start_job(input logic [7:0] cnt);
    rises    = 0;
    dones    = 0;
    n_push   = 0;
    start    = 1'b1;
    word_cnt = cnt;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; rises = 0; hi_run = 0; lo_run = 0; last_lo = 0;
    dones = 0; n_push = 0; last_acc = 1'b0; saw_full = 1'b0; cur_di = '0;
    reset = 1'b1; enb = 1'b1; start = 1'b0; word_cnt = '0; s_data = '0; s_valid = 1'b0;

    #2;
    chk("rst_di", bpbuf_di, 32'h0);
    chk("rst_wrn", 32'(bpbuf_ld_wrn), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ldcnt", 32'(ld_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word; start acts on the first edge after reset release
    start_job(8'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(s_ready), 32'd1);
    push_word(32'h5876063e);
    chk("t1_wrn_pre", 32'(bpbuf_ld_wrn), 32'd0);
    tick();
    chk("t1_wrn_latency", 32'(bpbuf_ld_wrn), 32'd1);
    chk("t1_di", bpbuf_di, 32'h5876063e);
    wait_done(20, "t1_done_seen");
    chk("t1_ldcnt", 32'(ld_count), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_di_hold", bpbuf_di, 32'h5876063e);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Two words back to back
    start_job(8'd2);
    push_word(32'h5876063e);
    push_word(32'haabb7788);
    wait_done(30, "t2_done_seen");
    chk("t2_rises", 32'(rises), 32'd2);
    chk("t2_gap_len", 32'(last_lo), 32'd2);
    chk("t2_ldcnt", 32'(ld_count), 32'd2);
    tick();
    tick();
    chk("t2_done_once", 32'(dones), 32'd1);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure with s_valid held high
    start_job(8'd8);
    saw_full = 1'b0;
    s_data   = 32'h1;
    s_valid  = 1'b1;
    for (int i = 0; i < 200 && s_valid; i++) begin
      chk("t3_ready_occ", 32'(s_ready), 32'((n_push - rises) < 4));
      if (!s_ready) saw_full = 1'b1;
      tick();
      if (last_acc) begin
        if (s_data == 32'h8) s_valid = 1'b0;
        else                 s_data  = s_data + 32'h1;
      end
    end
    s_valid = 1'b0;
    chk("t3_pushed", 32'(n_push), 32'd8);
    chk("t3_saw_full", 32'(saw_full), 32'd1);
    wait_done(200, "t3_done_seen");
    chk("t3_rises", 32'(rises), 32'd8);
    chk("t3_ldcnt", 32'(ld_count), 32'd8);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Enable freeze in the middle of LOAD
    start_job(8'd1);
    push_word(32'hc0ffee01);
    for (int i = 0; i < 10 && !bpbuf_ld_wrn; i++) tick();
    chk("t4_in_load", 32'(bpbuf_ld_wrn), 32'd1);
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_frz_wrn", 32'(bpbuf_ld_wrn), 32'd1);
      chk("t4_frz_ready", 32'(s_ready), 32'd0);
      chk("t4_frz_busy", 32'(busy), 32'd1);
    end
    enb = 1'b1;
    wait_done(20, "t4_done_seen");
    chk("t4_ldcnt", 32'(ld_count), 32'd1);

    // Zero count: done two cycles after start, no load
    start_job(8'd0);
    chk("t5_busy0", 32'(busy), 32'd0);
    chk("t5_done_early", 32'(done), 32'd0);
    tick();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_wrn", 32'(bpbuf_ld_wrn), 32'd0);
    chk("t5_ldcnt", 32'(ld_count), 32'd0);
    chk("t5_rises", 32'(rises), 32'd0);
    tick();
    chk("t5_done_pulse", 32'(done), 32'd0);

    // Stray start while busy must not change the latched count
    start_job(8'd2);
    push_word(32'h11110001);
    start    = 1'b1;
    word_cnt = 8'd5;
    tick();
    start    = 1'b0;
    push_word(32'h11110002);
    wait_done(40, "t5s_done_seen");
    chk("t5s_ldcnt", 32'(ld_count), 32'd2);
    chk("t5s_rises", 32'(rises), 32'd2);

    // Reset during GAP of word 2 of 4
    start_job(8'd4);
    for (int k = 0; k < 4; k++) push_word(32'hf0000000 + 32'(k));
    for (int i = 0; i < 60 && !(rises == 2 && !bpbuf_ld_wrn); i++) tick();
    chk("t6_in_gap2", 32'(rises == 2 && !bpbuf_ld_wrn), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_di", bpbuf_di, 32'h0);
    chk("t6_rst_wrn", 32'(bpbuf_ld_wrn), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(s_ready), 32'd0);
    chk("t6_rst_ldcnt", 32'(ld_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    hi_run = 0; lo_run = 0; dones = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_no_done", 32'(dones), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    start_job(8'd1);
    push_word(32'h600dcafe);
    wait_done(20, "t6_new_done");
    chk("t6_new_ldcnt", 32'(ld_count), 32'd1);
    chk("t6_new_di", bpbuf_di, 32'h600dcafe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/al_accel_bpbuf_feeder.md
AL_ACCEL_BPBUF_FEEDER -- requirements
Module: al_accel_bpbuf_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input word FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter LD_CYCLES, default 2, cycles bpbuf_ld_wrn is held high per word (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, cycles bpbuf_ld_wrn is held low between words (>=1).
REQ-004 SHALL have the following ports:
- clk  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- enb  input  1  global enable; 0 freezes the block.
- start  input  1  one-cycle pulse that begins a transfer job.
- word_cnt  input  8  words in the job, sampled on accepted start.
- s_data  input  32  upstream word.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block accepts s_data this cycle.
- bpbuf_di  output  32  word presented to the bypass buffer.
- bpbuf_ld_wrn  output  1  1 = load bypass buffer, 0 = hold.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse at job end.
- ld_count  output  8  words loaded in the current or last job.

Function
REQ-005 SHALL implement states IDLE, WAIT, LOAD, GAP, DONE.
REQ-006 SHALL, in IDLE with enb=1 and start=1, latch word_cnt, clear ld_count, and go to WAIT; if word_cnt=0, go to DONE instead.
REQ-007 SHALL ignore start in any state other than IDLE.
REQ-008 SHALL assert s_ready = enb & busy & !fifo_full, from registered state only, with no combinational path from s_valid.
REQ-009 SHALL push s_data into the FIFO on a rising edge where s_valid & s_ready, with no full-FIFO bypass.
REQ-010 SHALL, in WAIT with the FIFO non-empty, pop the head, register it onto bpbuf_di, increment ld_count, and enter LOAD on the same edge.
REQ-011 SHALL make the latency from a push into an empty FIFO in WAIT equal 1 cycle to bpbuf_ld_wrn=1, with bpbuf_di valid in that same cycle.
REQ-012 SHALL keep bpbuf_ld_wrn=1 for exactly LD_CYCLES cycles in LOAD, with bpbuf_di stable throughout, then enter GAP.
REQ-013 SHALL keep bpbuf_ld_wrn=0 for exactly GAP_CYCLES cycles in GAP, then go to DONE if ld_count = the latched count, else to WAIT.
REQ-014 SHALL, in DONE, assert done for 1 cycle, deassert busy, and go to IDLE.
REQ-015 SHALL make busy=1 in WAIT, LOAD and GAP, and 0 otherwise.
REQ-016 SHALL hold bpbuf_di at the last loaded word outside LOAD, and drive bpbuf_ld_wrn only from a register.
REQ-017 SHALL, while enb=0, freeze state, phase counters, FIFO, ld_count and outputs; s_ready=0 and done does not fire; resume exactly on re-enable.
REQ-018 SHALL stall in WAIT indefinitely on an empty FIFO, with bpbuf_ld_wrn=0.
REQ-019 SHALL, on a simultaneous push and pop, update the FIFO occupancy by net 0.
REQ-020 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-021 SHALL discard words left in the FIFO at DONE by clearing the FIFO on entry to IDLE.

Reset
REQ-022 SHALL, on reset=1, immediately set: state IDLE, FIFO empty, bpbuf_di=32'h0, bpbuf_ld_wrn=0, s_ready=0, busy=0, done=0, ld_count=0.
REQ-023 SHALL, on reset asserted mid-job (any state), abort the job with no done pulse and restart only on a new start.
REQ-024 SHALL act on the first start on the first rising edge after reset deasserts.

Verification
REQ-025 Single word: start with word_cnt=1; push 32'h5876063e -> next cycle bpbuf_di=32'h5876063e with ld_wrn=1 for 2 cycles; 0 for 2 cycles; done pulse; ld_count=1.
REQ-026 Two words back-to-back: word_cnt=2; s_data 32'h5876063e then 32'haabb7788 on consecutive cycles -> ld_wrn pattern 1,1,0,0,1,1,0,0; bpbuf_di follows in order; done once; ld_count=2.
REQ-027 Backpressure: word_cnt=8; s_valid held high with incrementing data from 32'h1 -> s_ready drops when 4 entries are held; no word lost or duplicated; loads show 1..8 in order.
REQ-028 Enable freeze: deassert enb for 5 cycles in the middle of LOAD -> ld_wrn stays 1 and the LOAD phase totals exactly 2 enabled cycles.
REQ-029 Zero count and stray start: word_cnt=0 -> done 2 cycles after start with no ld_wrn; a start while busy does not change the latched count.
REQ-030 Reset mid-job: assert reset during GAP of word 2 of 4 -> all outputs return to reset values immediately; no done; a new job with word_cnt=1 completes normally.
